ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive-side companion to the 8-bit one-hot ring counter.
- Samples the ring word, checks that it rotates correctly, decodes the hot position to a binary index, and counts full laps and sequence errors.
- Sits downstream of the ring counter as a phase decoder and health monitor. It drives no ring-counter inputs.

Parameters:
- WIDTH, 8: ring width in bits.
- IDX_W, 3: index width; must equal clog2(WIDTH).
- CNT_W, 8: width of lap_count and err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous: zero the counters and sticky_err, return to SEARCH.
- sample_en  input  1  ring_in is sampled on this cycle.
- ring_in  input  WIDTH  one-hot ring word from the ring counter.
- index  output  IDX_W  bit position of the hot bit in the last accepted sample.
- index_valid  output  1  index is meaningful; high only in LOCKED.
- locked  output  1  FSM is in LOCKED.
- lap_pulse  output  1  one-cycle pulse when the ring wraps from bit WIDTH-1 to bit 0.
- lap_count  output  CNT_W  completed laps; wraps modulo 2^CNT_W.
- err  output  1  one-cycle pulse on a sequence error.
- err_count  output  CNT_W  sequence errors; saturates at 2^CNT_W-1.
- sticky_err  output  1  set on any error; cleared only by rst or clear.

Behaviour:
- Definitions:
  - One-hot: ring_in != 0 and (ring_in & (ring_in-1)) == 0.
  - Rotation direction: left, so expected next = {cur[WIDTH-2:0], cur[WIDTH-1]}.
- Reset (rst=1, asynchronous):
  - state = SEARCH.
  - index = 0; expected register = 0.
  - index_valid, locked, lap_pulse, err, sticky_err = 0.
  - lap_count = 0; err_count = 0.
- Timing: all outputs are registered. The response to a sample appears in the cycle after the clk edge on which sample_en=1.
- sample_en=0: state, index and counters hold; lap_pulse and err are 0.
- FSM, SEARCH:
  - One-hot sample: load index = position, expected = rotl(sample), go to LOCKED.
  - Non-one-hot sample (zero or multi-hot): stay in SEARCH; no err.
  - index_valid = 0 and locked = 0 while in SEARCH.
- FSM, LOCKED:
  - sample == expected: update index and expected.
  - If the accepted sample is bit 0 and the previous index was WIDTH-1: lap_pulse = 1 and lap_count increments.
  - sample != expected (includes a held value, a skipped position, multi-hot or zero): go to FAULT, err = 1, err_count increments (saturating), sticky_err = 1.
- FSM, FAULT:
  - Lasts one cycle: index_valid = 0, locked = 0.
  - Next cycle returns to SEARCH unconditionally, ignoring that cycle's sample.
- clear:
  - Has priority over any same-cycle sample event.
  - Result: state = SEARCH; lap_count, err_count and sticky_err = 0; no err or lap_pulse in the following cycle.
- rst asserted mid-lap: asynchronous return to reset values, with no glitch pulse on err or lap_pulse.
- Simultaneous lap and counter wrap: lap_count wraps 2^CNT_W-1 → 0; lap_pulse still fires.
- The first lock never generates lap_pulse, even if the first sample is bit 0.
- index uses only IDX_W bits; WIDTH not a power of two is unsupported.

Test Plan:
- Reset: assert rst=1 asynchronously, between clk edges → immediately locked=0, index_valid=0, index=0, lap_count=0, err_count=0, sticky_err=0.
- Clean rotation: sample_en=1; feed 0x01,0x02,0x04,…,0x80,0x01,0x02 → locked from the 2nd cycle; index 0,1,…,7,0,1; lap_pulse exactly once (after 0x01 follows 0x80); lap_count=1; err=0 throughout.
- Skip error: locked at index 2 (0x04), feed 0x10 → err=1 for one cycle, err_count=1, sticky_err=1, locked=0. Then feed 0x20 (ignored in FAULT), 0x40 (relock) → index=6, locked=1.
- Illegal words in SEARCH: feed 0x00, then 0x03 → locked stays 0, err_count=0. Then feed 0x08 → locked=1, index=3.
- Hold and enable: locked at 0x02 with sample_en=0 for 5 cycles while ring_in changes → no state change. With sample_en=1 and ring_in held at 0x02 → err=1.
- Priority and saturation: drive 255 errors (CNT_W=8) → err_count stays 255 on the 256th. Then assert clear in the same cycle as a mismatching sample → err=0, err_count=0, sticky_err=0, state SEARCH.

Source files
------------

// File: rtl/ring_decoder.sv
// ring_decoder: receive-side phase decoder and health monitor for a one-hot
// ring counter that rotates left.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   clear        synchronous clear of counters/sticky_err, back to SEARCH
//   sample_en    ring_in is sampled this cycle
//   ring_in      one-hot ring word
//   index        bit position of the hot bit in the last accepted sample
//   index_valid  index meaningful (LOCKED only)
//   locked       FSM in LOCKED
//   lap_pulse    one-cycle pulse on wrap from bit WIDTH-1 to bit 0
//   lap_count    completed laps, wraps
//   err          one-cycle pulse on a sequence error
//   err_count    sequence errors, saturating
//   sticky_err   set on any error until rst or clear
module ring_decoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             locked,
  output logic             lap_pulse,
  output logic [CNT_W-1:0] lap_count,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             sticky_err
);

  typedef enum logic [1:0] {SEARCH, LOCKED, FAULT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] expected, expected_nx;
  logic [IDX_W-1:0] index_nx;
  logic             lap_nx, err_nx, sticky_nx;
  logic [CNT_W-1:0] lap_count_nx, err_count_nx;

  logic             one_hot;
  logic [IDX_W-1:0] pos;
  logic [WIDTH-1:0] rot;

  assign one_hot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign rot     = {ring_in[WIDTH-2:0], ring_in[WIDTH-1]};

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) pos = IDX_W'(i);
    end
  end

  always_comb begin
    state_nx     = state;
    expected_nx  = expected;
    index_nx     = index;
    lap_nx       = 1'b0;
    err_nx       = 1'b0;
    sticky_nx    = sticky_err;
    lap_count_nx = lap_count;
    err_count_nx = err_count;
    if (clear) begin
      state_nx     = SEARCH;
      sticky_nx    = 1'b0;
      lap_count_nx = '0;
      err_count_nx = '0;
    end else begin
      case (state)
        SEARCH: begin
          if (sample_en && one_hot) begin
            index_nx    = pos;
            expected_nx = rot;
            state_nx    = LOCKED;
          end
        end
        LOCKED: begin
          if (sample_en) begin
            if (ring_in == expected) begin
              index_nx    = pos;
              expected_nx = rot;
              if (ring_in[0] && (index == IDX_W'(WIDTH - 1))) begin
                lap_nx       = 1'b1;
                lap_count_nx = lap_count + CNT_W'(1);
              end
            end else begin
              state_nx  = FAULT;
              err_nx    = 1'b1;
              sticky_nx = 1'b1;
              if (err_count != '1) err_count_nx = err_count + CNT_W'(1);
            end
          end
        end
        default: state_nx = SEARCH;  // FAULT lasts exactly one cycle
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      expected   <= '0;
      index      <= '0;
      lap_pulse  <= 1'b0;
      err        <= 1'b0;
      sticky_err <= 1'b0;
      lap_count  <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nx;
      expected   <= expected_nx;
      index      <= index_nx;
      lap_pulse  <= lap_nx;
      err        <= err_nx;
      sticky_err <= sticky_nx;
      lap_count  <= lap_count_nx;
      err_count  <= err_count_nx;
    end
  end

  assign locked      = (state == LOCKED);
  assign index_valid = (state == LOCKED);

endmodule

// File: tb/tb_ring_decoder.sv
// Testbench for ring_decoder: directed scenarios plus randomized traffic,
// checked every cycle against a position-based reference model.
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] ring_in = '0;
  logic [2:0] index;
  logic       index_valid, locked, lap_pulse, err, sticky_err;
  logic [7:0] lap_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mode 0=search, 1=locked, 2=fault
  int m_mode = 0, m_idx = 0, m_lapcnt = 0, m_errcnt = 0;
  bit m_lp = 0, m_er = 0, m_sticky = 0;

  ring_decoder #(.WIDTH(8), .IDX_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_en(sample_en),
    .ring_in(ring_in), .index(index), .index_valid(index_valid),
    .locked(locked), .lap_pulse(lap_pulse), .lap_count(lap_count),
    .err(err), .err_count(err_count), .sticky_err(sticky_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hot_pos(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic model(input logic c, input logic e, input logic [7:0] r);
    logic [7:0] want;
    m_lp = 0;
    m_er = 0;
    if (c) begin
      m_mode = 0; m_lapcnt = 0; m_errcnt = 0; m_sticky = 0;
    end else if (m_mode == 0) begin
      if (e && $countones(r) == 1) begin
        m_idx = hot_pos(r);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (e) begin
        want = 8'(1 << ((m_idx + 1) % 8));
        if (r == want) begin
          if (m_idx == 7) begin
            m_lp = 1;
            m_lapcnt = (m_lapcnt + 1) % 256;
          end
          m_idx = hot_pos(r);
        end else begin
          m_mode = 2; m_er = 1; m_sticky = 1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_mode == 1));
    check("index_valid", 32'(index_valid), 32'(m_mode == 1));
    check("index", 32'(index), 32'(m_idx));
    check("lap_pulse", 32'(lap_pulse), 32'(m_lp));
    check("err", 32'(err), 32'(m_er));
    check("lap_count", 32'(lap_count), 32'(m_lapcnt));
    check("err_count", 32'(err_count), 32'(m_errcnt));
    check("sticky_err", 32'(sticky_err), 32'(m_sticky));
  endtask

  task automatic step(input logic c, input logic e, input logic [7:0] r);
    @(negedge clk);
    clear = c;
    sample_en = e;
    ring_in = r;
    @(posedge clk);
    model(c, e, r);
    #1 compare_all();
  endtask

  // asynchronous reset asserted between clock edges
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m_mode = 0; m_idx = 0; m_lapcnt = 0; m_errcnt = 0;
    m_lp = 0; m_er = 0; m_sticky = 0;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    sample_en = 1'b0;
  endtask

  function automatic logic [7:0] oh(input int p);
    return 8'(1 << (p % 8));
  endfunction

  initial begin
    logic [7:0] r;
    // power-on reset
    @(negedge clk);
    #1 compare_all();
    rst = 1'b0;

    // clean rotation: 0x01..0x80, 0x01, 0x02
    for (int i = 0; i < 10; i++) step(0, 1, oh(i));

    // reset mid-lap
    step(0, 1, oh(2));
    async_reset();

    // skip error then relock
    step(0, 1, 8'h01); step(0, 1, 8'h02); step(0, 1, 8'h04);
    step(0, 1, 8'h10);
    step(0, 1, 8'h20);
    step(0, 1, 8'h40);

    // illegal words in SEARCH
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h03);
    step(0, 1, 8'h08);

    // hold with enable low, then held value with enable high
    step(1, 0, 8'h00);
    step(0, 1, 8'h02);
    for (int i = 0; i < 5; i++) step(0, 0, 8'($urandom));
    step(0, 1, 8'h02);
    step(0, 1, 8'h00);

    // error saturation: 256 lock/mismatch/fault rounds
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 8'h01);
      step(0, 1, 8'h01);
      step(0, 1, 8'h00);
    end
    check("err_sat", 32'(err_count), 32'd255);
    // clear beats a same-cycle mismatching sample
    step(0, 1, 8'h01);
    step(1, 1, 8'h80);
    check("clear_err", 32'(err_count), 32'd0);

    // lap counter wrap: 257 laps
    step(0, 1, 8'h01);
    for (int i = 1; i <= 257 * 8; i++) step(0, 1, oh(i));
    check("lap_wrap", 32'(lap_count), 32'd1);

    // randomized traffic
    r = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 60)      r = {r[6:0], r[7]};
      else if (k < 75) r = oh($urandom_range(0, 7));
      else if (k < 82) r = 8'h00;
      else if (k < 90) r = 8'($urandom);
      if (r == 8'h00 && k >= 82) r = 8'h00;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85), r);
      if (r == 8'h00 && $urandom_range(0, 3) == 0) r = 8'h01;
    end

    // reset during random traffic
    step(0, 1, 8'h10);
    async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
